// File: rtl/red_pitaya_filter_pkg.sv
// rtl/red_pitaya_filter_pkg.sv - shared types, field constants and target sanitiser for the filter sequencer
// Purpose: state encoding, set_filter byte layout and the mask applied to every requested target.
// Ports: none (package).
package red_pitaya_filter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_SETTLE,
        ST_DONE
    } fsm_state_e;

    localparam int FILT_ON_BIT    = 7;
    localparam int FILT_HP_BIT    = 6;
    localparam int FILT_SHIFT_LSB = 0;
    localparam int FILT_BYTE_W    = 8;
    localparam int MAX_STAGES     = 4;

    // Keeps only filter_on, highpass and the low 'shiftbits' shift bits of each
    // stage byte; bytes of stages that are not driven are cleared entirely.
    function automatic logic [31:0] sanitise(input logic [31:0] word,
                                             input int          stages,
                                             input int          shiftbits);
        logic [31:0] res;
        logic [7:0]  b_in;
        logic [7:0]  b_out;
        res = '0;
        for (int j = 0; j < MAX_STAGES; j++) begin
            b_in  = word[j*FILT_BYTE_W +: FILT_BYTE_W];
            b_out = '0;
            b_out[FILT_ON_BIT] = b_in[FILT_ON_BIT];
            b_out[FILT_HP_BIT] = b_in[FILT_HP_BIT];
            for (int k = FILT_SHIFT_LSB; k < FILT_HP_BIT; k++) begin
                if ((k - FILT_SHIFT_LSB) < shiftbits) begin
                    b_out[k] = b_in[k];
                end
            end
            if (j < stages) begin
                res[j*FILT_BYTE_W +: FILT_BYTE_W] = b_out;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/red_pitaya_filter_sequencer_if.sv
// rtl/red_pitaya_filter_sequencer_if.sv - request/status bundle between register bank and filter sequencer
// Purpose: groups the target request inputs and the set_filter/status outputs.
// Ports: target_i, update_i, settle_cycles_i (to sequencer); set_filter_o, busy_o, hold_o, done_o, pending_o (from sequencer).
interface red_pitaya_filter_sequencer_if #(
    parameter int SETTLEBITS = 16
);
    logic [31:0]           target_i;
    logic                  update_i;
    logic [SETTLEBITS-1:0] settle_cycles_i;
    logic [31:0]           set_filter_o;
    logic                  busy_o;
    logic                  hold_o;
    logic                  done_o;
    logic                  pending_o;

    modport master (
        output target_i, update_i, settle_cycles_i,
        input  set_filter_o, busy_o, hold_o, done_o, pending_o
    );

    modport slave (
        input  target_i, update_i, settle_cycles_i,
        output set_filter_o, busy_o, hold_o, done_o, pending_o
    );
endinterface

// File: rtl/red_pitaya_settle_timer.sv
// rtl/red_pitaya_settle_timer.sv - loadable down-counter with zero flag
// Purpose: counts a programmed number of cycles down to zero and then holds at zero.
// Ports: clk_i, rstn_i (async active-low), load_i/value_i (load), zero_o (counter is zero).
module red_pitaya_settle_timer #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= value_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/red_pitaya_filter_sequencer.sv
// rtl/red_pitaya_filter_sequencer.sv - applies a new set_filter word one stage at a time with settle waits
// Purpose: owns set_filter, walks stages in ascending order, writes only changed bytes, waits after each write.
// Ports: clk_i, rstn_i (async active-low), bus (slave: target/update/settle in, set_filter/busy/hold/done/pending out).
module red_pitaya_filter_sequencer
    import red_pitaya_filter_pkg::*;
#(
    parameter int STAGES     = 1,
    parameter int SHIFTBITS  = 4,
    parameter int SETTLEBITS = 16
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    red_pitaya_filter_sequencer_if.slave  bus
);

    localparam logic [1:0] LAST_IDX = 2'(STAGES - 1);

    fsm_state_e  state_q;
    logic [1:0]  idx_q;
    logic [31:0] tgt_q;
    logic [31:0] pend_q;
    logic [31:0] set_q;
    logic        pending_q;
    logic        busy_q;
    logic        done_q;

    logic [31:0] target_san;
    logic [4:0]  bit_base;
    logic        stage_diff;
    logic        last_stage;
    logic        timer_load;
    logic        timer_zero;

    assign target_san = sanitise(bus.target_i, STAGES, SHIFTBITS);
    assign bit_base   = {idx_q, 3'b000};
    assign stage_diff = tgt_q[bit_base +: FILT_BYTE_W] != set_q[bit_base +: FILT_BYTE_W];
    assign last_stage = (idx_q == LAST_IDX);
    // The counter is loaded on the same edge that writes the byte, so SETTLE
    // sees settle_cycles_i first and lasts settle_cycles_i+1 cycles.
    assign timer_load = (state_q == ST_SCAN) && stage_diff;

    red_pitaya_settle_timer #(
        .W (SETTLEBITS)
    ) u_settle_timer (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .load_i  (timer_load),
        .value_i (bus.settle_cycles_i),
        .zero_o  (timer_zero)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            tgt_q     <= '0;
            pend_q    <= '0;
            set_q     <= '0;
            pending_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;

            // Requests arriving mid-sequence are parked; the newest one wins.
            if (state_q != ST_IDLE && bus.update_i) begin
                pend_q    <= target_san;
                pending_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (bus.update_i) begin
                        tgt_q   <= target_san;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (stage_diff) begin
                        set_q[bit_base +: FILT_BYTE_W] <= tgt_q[bit_base +: FILT_BYTE_W];
                        state_q <= ST_SETTLE;
                    end else if (last_stage) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        idx_q <= idx_q + 2'd1;
                    end
                end
                ST_SETTLE: begin
                    if (timer_zero) begin
                        if (last_stage) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            idx_q   <= idx_q + 2'd1;
                            state_q <= ST_SCAN;
                        end
                    end
                end
                ST_DONE: begin
                    // A request seen in this very cycle counts as pending and
                    // takes priority over an older parked one.
                    if (pending_q || bus.update_i) begin
                        tgt_q     <= bus.update_i ? target_san : pend_q;
                        pending_q <= 1'b0;
                        idx_q     <= '0;
                        state_q   <= ST_SCAN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.set_filter_o = set_q;
    assign bus.busy_o       = busy_q;
    assign bus.hold_o       = busy_q;
    assign bus.done_o       = done_q;
    assign bus.pending_o    = pending_q;

endmodule

// File: tb/tb_red_pitaya_filter_sequencer.sv
// tb/tb_red_pitaya_filter_sequencer.sv - self-checking bench for the filter sequencer against a timeline model
module tb_red_pitaya_filter_sequencer;

    localparam int ST_A  = 4;
    localparam int ST_B  = 2;
    localparam int SHIFT = 4;
    localparam int SB    = 16;

    logic clk_i;
    logic rstn_i;

    red_pitaya_filter_sequencer_if #(.SETTLEBITS(SB)) bus_a ();
    red_pitaya_filter_sequencer_if #(.SETTLEBITS(SB)) bus_b ();

    red_pitaya_filter_sequencer #(.STAGES(ST_A), .SHIFTBITS(SHIFT), .SETTLEBITS(SB)) u_dut_a (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .bus    (bus_a.slave)
    );

    red_pitaya_filter_sequencer #(.STAGES(ST_B), .SHIFTBITS(SHIFT), .SETTLEBITS(SB)) u_dut_b (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .bus    (bus_b.slave)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    int          cyc = 0;
    logic [31:0] last_word = '0;
    logic [31:0] cur_word = '0;
    logic        last_busy = 1'b0;
    int          busy_cnt, done_cnt, done_cyc, multi_err, hold_err;
    int          wlog_cyc[$];
    int          wlog_byte[$];
    logic [7:0]  wlog_val[$];
    int          exp_cyc[$];
    int          exp_byte[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_san(input logic [31:0] w, input int stages);
        logic [31:0] r;
        logic [7:0]  keep;
        r    = '0;
        keep = 8'hC0 | 8'((1 << SHIFT) - 1);
        for (int j = 0; j < stages; j++) r[j*8 +: 8] = w[j*8 +: 8] & keep;
        return r;
    endfunction

    // Timeline: sample 1 after the update edge is the first stage check; a
    // changed stage shows its new byte one sample later and then costs
    // settle+1 more samples; an unchanged stage costs one; the last busy
    // sample is the done cycle.
    task automatic model_seq(input logic [31:0] cur, input logic [31:0] tgt, input int settle,
                             input int stages, output int dur);
        int t;
        exp_cyc.delete();
        exp_byte.delete();
        t = 1;
        for (int j = 0; j < stages; j++) begin
            if (cur[j*8 +: 8] != tgt[j*8 +: 8]) begin
                exp_cyc.push_back(t + 1);
                exp_byte.push_back(j);
                t += settle + 2;
            end else begin
                t += 1;
            end
        end
        dur = t;
    endtask

    task automatic clear_logs();
        busy_cnt = 0;
        done_cnt = 0;
        done_cyc = -1;
        wlog_cyc.delete();
        wlog_byte.delete();
        wlog_val.delete();
    endtask

    task automatic tick();
        logic [31:0] diff;
        int nb;
        @(negedge clk_i);
        cyc++;
        diff = bus_a.set_filter_o ^ last_word;
        nb = 0;
        for (int j = 0; j < 4; j++) begin
            if (diff[j*8 +: 8] != 8'h00) begin
                nb++;
                wlog_cyc.push_back(cyc);
                wlog_byte.push_back(j);
                wlog_val.push_back(bus_a.set_filter_o[j*8 +: 8]);
            end
        end
        if (nb > 1) multi_err++;
        last_word = bus_a.set_filter_o;
        last_busy = bus_a.busy_o;
        if (bus_a.busy_o) busy_cnt++;
        if (bus_a.done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus_a.hold_o !== bus_a.busy_o) hold_err++;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (last_busy && guard < 3000) begin
            tick();
            guard++;
        end
        check("idle_timeout", 32'(guard < 3000), 32'd1);
    endtask

    task automatic run_seq(input logic [31:0] target, input int settle, input string tag);
        logic [31:0] tgt_s;
        int dur, start, n;
        tgt_s = model_san(target, ST_A);
        model_seq(cur_word, tgt_s, settle, ST_A, dur);
        clear_logs();
        bus_a.target_i        = target;
        bus_a.settle_cycles_i = SB'(settle);
        bus_a.update_i        = 1'b1;
        start = cyc;
        tick();
        bus_a.update_i = 1'b0;
        wait_idle();
        check({tag, "_busy"}, 32'(busy_cnt), 32'(dur));
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        check({tag, "_done_cyc"}, 32'(done_cyc - start), 32'(dur));
        check({tag, "_word"}, bus_a.set_filter_o, tgt_s);
        check({tag, "_nwrites"}, 32'(wlog_cyc.size()), 32'(exp_cyc.size()));
        n = (wlog_cyc.size() < exp_cyc.size()) ? wlog_cyc.size() : exp_cyc.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_wr_cyc"}, 32'(wlog_cyc[i] - start), 32'(exp_cyc[i]));
            check({tag, "_wr_byte"}, 32'(wlog_byte[i]), 32'(exp_byte[i]));
        end
        cur_word = tgt_s;
    endtask

    initial begin
        logic [31:0] t, tgt1, tgt_b;
        int d1, d2, start, guard, bad_hi, bad_val;

        multi_err = 0;
        hold_err  = 0;
        rstn_i    = 1'b0;
        bus_a.target_i = '0; bus_a.update_i = 1'b0; bus_a.settle_cycles_i = '0;
        bus_b.target_i = '0; bus_b.update_i = 1'b0; bus_b.settle_cycles_i = '0;
        #3;
        check("rst_word", bus_a.set_filter_o, 32'h0);
        check("rst_flags", {28'h0, bus_a.busy_o, bus_a.hold_o, bus_a.done_o, bus_a.pending_o}, 32'h0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        clear_logs();
        tick(); tick();
        check("post_rst_busy", 32'(busy_cnt), 32'd0);

        // First update and repeat of the same target (no byte writes).
        run_seq(32'h0000_0085, 3, "first");
        run_seq(32'h0000_0085, 3, "nochange");

        // Masking on the two-stage instance.
        tgt_b = 32'hFFFF_FFFF;
        model_seq(32'h0, model_san(tgt_b, ST_B), 1, ST_B, d1);
        bus_b.target_i = tgt_b; bus_b.settle_cycles_i = SB'(1); bus_b.update_i = 1'b1;
        @(negedge clk_i);
        bus_b.update_i = 1'b0;
        bad_hi = 0; d2 = 0; guard = 0;
        while (bus_b.busy_o && guard < 200) begin
            d2++;
            if (bus_b.set_filter_o[31:16] != 16'h0) bad_hi++;
            @(negedge clk_i);
            guard++;
        end
        check("mask_word", bus_b.set_filter_o, 32'h0000_CFCF);
        check("mask_hi_bytes", 32'(bad_hi), 32'd0);
        check("mask_busy", 32'(d2), 32'(d1));

        // Queued updates during stage-0 settle; only the newest is applied.
        tgt1 = 32'h0000_0088;
        model_seq(cur_word, tgt1, 6, ST_A, d1);
        model_seq(tgt1, 32'h0000_0283, 6, ST_A, d2);
        clear_logs();
        bus_a.target_i = tgt1; bus_a.settle_cycles_i = SB'(6); bus_a.update_i = 1'b1;
        start = cyc;
        tick();
        bus_a.update_i = 1'b0;
        tick();
        bus_a.target_i = 32'h0000_0182; bus_a.update_i = 1'b1;
        tick();
        bus_a.target_i = 32'h0000_0283;
        tick();
        bus_a.update_i = 1'b0;
        check("queue_pending", 32'(bus_a.pending_o), 32'd1);
        wait_idle();
        check("queue_busy", 32'(busy_cnt), 32'(d1 + d2));
        check("queue_done_cnt", 32'(done_cnt), 32'd2);
        check("queue_word", bus_a.set_filter_o, 32'h0000_0283);
        check("queue_pending_clr", 32'(bus_a.pending_o), 32'd0);
        bad_val = 0;
        foreach (wlog_cyc[i]) if (wlog_byte[i] == 1 && wlog_val[i] == 8'h01) bad_val++;
        check("queue_0182_unused", 32'(bad_val), 32'd0);
        cur_word = 32'h0000_0283;

        // Random targets, some bytes reused from the current word.
        for (int it = 0; it < 20; it++) begin
            t = $urandom;
            for (int j = 0; j < 4; j++) if ($urandom_range(0, 1) == 0) t[j*8 +: 8] = cur_word[j*8 +: 8];
            run_seq(t, int'($urandom_range(0, 4)), "rand");
        end

        // Asynchronous reset during stage-2 settle.
        clear_logs();
        bus_a.target_i = cur_word ^ 32'h0081_8181; bus_a.settle_cycles_i = SB'(10); bus_a.update_i = 1'b1;
        tick();
        bus_a.update_i = 1'b0;
        guard = 0;
        while (wlog_cyc.size() < 3 && guard < 200) begin
            tick();
            guard++;
        end
        check("rst_mid_reach_stage2", 32'(wlog_byte.size() >= 3 ? wlog_byte[2] : -1), 32'd2);
        tick(); tick(); tick();
        #2;
        rstn_i = 1'b0;
        #1;
        check("rst_mid_word", bus_a.set_filter_o, 32'h0);
        check("rst_mid_flags", {28'h0, bus_a.busy_o, bus_a.hold_o, bus_a.done_o, bus_a.pending_o}, 32'h0);
        last_word = 32'h0;
        tick();
        rstn_i = 1'b1;
        clear_logs();
        for (int i = 0; i < 5; i++) tick();
        check("rst_mid_idle_busy", 32'(busy_cnt), 32'd0);
        check("rst_mid_idle_writes", 32'(wlog_cyc.size()), 32'd0);
        cur_word = 32'h0;

        // Zero settle, all four stages changed.
        run_seq(32'h8181_8181, 0, "zero_settle");

        check("one_byte_per_edge", 32'(multi_err), 32'd0);
        check("hold_eq_busy", 32'(hold_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
